// File: rtl/downcount_timer.sv
// ----------------------------------------------------------------------------
// downcount_timer
//
// Purpose:
//   Loadable N-bit down-counter / interval timer. A load captures R into both
//   the count and an internal reload register. While running, each enabled
//   step decrements the count. When the count reaches its terminal step
//   (Q == 1), TC is pulsed for one cycle. The timer then either reloads from
//   the saved value (auto-reload) or parks at zero in DONE (one-shot).
//
// Configuration:
//   DOWNCOUNT_PRESCALE_EN  When defined, an internal prescaler limits steps
//                          to one per PRESCALE enabled RUN cycles. When
//                          undefined, every enabled RUN cycle is a step and
//                          PRESCALE has no effect.
//
// Parameters:
//   N         counter width in bits (>= 2)
//   PRESCALE  enabled cycles per step when the prescaler is built (>= 2)
//
// Ports:
//   Clock   in   1  rising-edge clock
//   Resetn  in   1  asynchronous, active-low reset
//   R       in   N  load value
//   L       in   1  load strobe (Q <= R, reload <= R); overrides E
//   E       in   1  count enable
//   Auto    in   1  1 = auto-reload, 0 = one-shot; sampled at each terminal step
//   Q       out  N  current count (registered)
//   TC      out  1  one-cycle terminal-count pulse (registered)
//   Busy    out  1  state == RUN
//   Done    out  1  state == DONE (one-shot finished)
// ----------------------------------------------------------------------------
module downcount_timer #(
    parameter int unsigned N        = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic [N-1:0] R,
    input  logic         L,
    input  logic         E,
    input  logic         Auto,
    output logic [N-1:0] Q,
    output logic         TC,
    output logic         Busy,
    output logic         Done
);

    // Elaboration-time parameter sanity check.
    if (N < 2 || PRESCALE < 2) begin : g_param_check
        $error("downcount_timer: N and PRESCALE must both be >= 2");
    end

    localparam logic [N-1:0] CNT_ONE = N'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [N-1:0] r_q;
    logic [N-1:0] r_reload;
    logic         r_tc;

    logic         w_run_en;   // enabled cycle while running
    logic         w_tick;     // this enabled cycle is a step
    logic         w_term;     // terminal step: Q == 1 on a step
    logic         w_dec;      // ordinary decrement: Q > 1 on a step
    logic         w_load_run; // load of a non-zero value

    always_comb begin
        w_run_en   = (r_state == S_RUN) && E;
        w_load_run = (R != '0);
    end

`ifdef DOWNCOUNT_PRESCALE_EN
    localparam int unsigned  PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;

    // Advances only on enabled RUN cycles; a load restarts the interval.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_pre <= '0;
        end else if (L) begin
            r_pre <= '0;
        end else if (w_run_en) begin
            if (r_pre == PRE_LAST) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

    always_comb begin
        w_tick = w_run_en && (r_pre == PRE_LAST);
    end
`else
    always_comb begin
        w_tick = w_run_en;
    end
`endif

    // Q == 0 while in RUN is unreachable (a zero load goes to IDLE), but a
    // step from 0 is still excluded so the count can never wrap.
    always_comb begin
        w_term = w_tick && (r_q == CNT_ONE);
        w_dec  = w_tick && (r_q > CNT_ONE);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (load outranks everything, in every state)
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (L) begin
            w_next_state = w_load_run ? S_RUN : S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: w_next_state = S_IDLE;
                S_RUN: begin
                    if (w_term && !Auto) begin
                        w_next_state = S_DONE;
                    end
                end
                S_DONE:  w_next_state = S_DONE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode (registered state only, no input paths)
    // ------------------------------------------------------------------
    always_comb begin
        Busy = (r_state == S_RUN);
        Done = (r_state == S_DONE);
        Q    = r_q;
        TC   = r_tc;
    end

    // ------------------------------------------------------------------
    // Datapath: count, reload value and terminal-count pulse
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_q      <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else if (L) begin
            r_q      <= R;
            r_reload <= R;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (w_term) begin
                r_tc <= 1'b1;
                r_q  <= Auto ? r_reload : '0;
            end else if (w_dec) begin
                r_q <= r_q - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_downcount_timer.sv
// ----------------------------------------------------------------------------
// tb_downcount_timer
//
// Scoreboard bench for downcount_timer (N=4, PRESCALE=4). The driver issues
// one input vector per cycle, advances a behavioural timer model and queues
// the outputs expected after the next clock edge. A separate monitor pops one
// entry after every rising edge and compares it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_downcount_timer;

    localparam int unsigned N        = 4;
    localparam int unsigned PRESCALE = 4;

    logic         Clock = 1'b0;
    logic         Resetn;
    logic [N-1:0] R;
    logic         L;
    logic         E;
    logic         Auto;
    logic [N-1:0] Q;
    logic         TC;
    logic         Busy;
    logic         Done;

    downcount_timer #(.N(N), .PRESCALE(PRESCALE)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .R      (R),
        .L      (L),
        .E      (E),
        .Auto   (Auto),
        .Q      (Q),
        .TC     (TC),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int unsigned q;
        bit          tc;
        bit          busy;
        bit          done;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: remaining count, saved interval, phase (idle / counting /
    // finished) and the number of enabled cycles spent in the current step.
    int unsigned m_count;
    int unsigned m_interval;
    bit          m_counting;
    bit          m_finished;
    bit          m_pulse;
    int unsigned m_subcycles;

    task automatic model_reset();
        m_count    = 0;
        m_interval = 0;
        m_counting = 0;
        m_finished = 0;
        m_pulse    = 0;
        m_subcycles = 0;
    endtask

    task automatic model_step(input bit ld, input int unsigned rv,
                              input bit en, input bit au);
        bit step_now;
        m_pulse = 0;
        if (ld) begin
            m_count     = rv;
            m_interval  = rv;
            m_counting  = (rv != 0);
            m_finished  = 0;
            m_subcycles = 0;
        end else if (m_counting && en) begin
`ifdef DOWNCOUNT_PRESCALE_EN
            m_subcycles = m_subcycles + 1;
            step_now    = (m_subcycles == PRESCALE);
            if (step_now) m_subcycles = 0;
`else
            step_now = 1;
`endif
            if (step_now) begin
                if (m_count == 1) begin
                    m_pulse = 1;
                    if (au) begin
                        m_count = m_interval;
                    end else begin
                        m_count    = 0;
                        m_counting = 0;
                        m_finished = 1;
                    end
                end else if (m_count > 1) begin
                    m_count = m_count - 1;
                end
            end
        end
    endtask

    task automatic check(input string name, input int unsigned act,
                         input int unsigned req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus; expectation is for the following edge.
    task automatic cyc(input bit ld, input int unsigned rv, input bit en,
                       input bit au);
        exp_t e;
        @(negedge Clock);
        L    = ld;
        R    = N'(rv);
        E    = en;
        Auto = au;
        model_step(ld, rv, en, au);
        e.q    = m_count;
        e.tc   = m_pulse;
        e.busy = m_counting;
        e.done = m_finished;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison set per rising edge with a pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("Q",    32'(Q),    e.q);
                check("TC",   32'(TC),   32'(e.tc));
                check("Busy", 32'(Busy), 32'(e.busy));
                check("Done", 32'(Done), 32'(e.done));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetn = 1'b0;
        L = 1'b0; R = '0; E = 1'b0; Auto = 1'b0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check("reset_Q",    32'(Q),    0);
        check("reset_TC",   32'(TC),   0);
        check("reset_Busy", 32'(Busy), 0);
        check("reset_Done", 32'(Done), 0);
        @(negedge Clock);
        Resetn = 1'b1;

        // Asynchronous reset while running with Q=5.
        cyc(1, 5, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        check("async_Q",    32'(Q),    0);
        check("async_TC",   32'(TC),   0);
        check("async_Busy", 32'(Busy), 0);
        check("async_Done", 32'(Done), 0);
        model_reset();
        #1 Resetn = 1'b1;

        // One-shot from 3 with E held, then 5 idle cycles in DONE.
        cyc(1, 3, 1, 0);
        repeat (8) cyc(0, 0, 1, 0);

        // Auto-reload from 2.
        cyc(1, 2, 1, 1);
        repeat (6) cyc(0, 0, 1, 1);

        // Enable gaps, then load in the same cycle as a would-be step.
        cyc(1, 4, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 9, 1, 0);
        cyc(0, 0, 0, 0);

        // Loading 0 parks in IDLE without TC.
        cyc(1, 0, 1, 0);
        repeat (4) cyc(0, 0, 1, 1);

        // Auto-reload with interval 1, then Auto dropped mid-run.
        cyc(1, 1, 1, 1);
        repeat (4) cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);

        // Terminal step coinciding with a load.
        cyc(1, 2, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 6, 1, 0);
        repeat (30) cyc(0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit          ld;
            int unsigned rv;
            ld = ($urandom_range(0, 9) == 0);
            rv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2)
                                             : $urandom_range(0, (1 << N) - 1);
            cyc(ld, rv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end

        @(negedge Clock);
        L = 1'b0; E = 1'b0;
        repeat (3) @(posedge Clock);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
